usbh_nes_joypad: RTL and testbench
==================================

USBH_NES_JOYPAD -- requirements
Module: usbh_nes_joypad

Interface
REQ-001 SHALL have parameter c_clk_hz, default 6000000: i_clk frequency in Hz.
REQ-002 SHALL have parameter c_reset_hold_ms, default 500: time i_btn[8] must be held before o_reset asserts.
REQ-003 SHALL have parameter c_block_opposite, default 1: 1 enables suppression of opposite directions.
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_btn  input  9  decoder button state {reset,R,L,D,U,start,select,B,A}, 1=pressed, not assumed synchronous.
REQ-007 SHALL have port i_strobe  input  1  NES $4016 bit0 level, synchronous to i_clk.
REQ-008 SHALL have port i_read  input  1  one-cycle pulse per CPU read of the joypad port.
REQ-009 SHALL have port o_data  output  1  serial data bit presented to the CPU, 1=pressed.
REQ-010 SHALL have port o_bitcnt  output  4  reads since last strobe, saturating at 8.
REQ-011 SHALL have port o_reset  output  1  console reset request.

Function
REQ-012 SHALL pass i_btn through a two-flop synchronizer (2-cycle latency).
REQ-013 SHALL register a filtered state btn_f[8:0] one cycle after the synchronizer (3 cycles total from i_btn).
REQ-014 With c_block_opposite=1, SHALL clear both U and D in btn_f when both are set, and clear both L and R when both are set.
REQ-015 Exception: when U, D, L and R are all set, SHALL pass all four unchanged.
REQ-016 SHALL hold an 8-bit shift register sr; bit 0 drives o_data directly from the register.
REQ-017 While i_strobe=1, SHALL load sr <= btn_f[7:0] every cycle and clear o_bitcnt to 0; i_read SHALL be ignored for shifting.
REQ-018 While i_strobe=0 and i_read=1, SHALL shift sr right by one, fill bit 7 with 1, and increment o_bitcnt, saturating at 8.
REQ-019 Read order SHALL be A, B, Select, Start, Up, Down, Left, Right; from the 9th read onward o_data SHALL be 1.
REQ-020 o_data SHALL reflect the new bit on the cycle after the i_read pulse.
REQ-021 Strobe falling edge SHALL freeze the last loaded value; button changes afterwards SHALL NOT affect sr until the next strobe.
REQ-022 If i_strobe and i_read are both 1 in the same cycle, load SHALL win.
REQ-023 Hold counter SHALL count cycles while btn_f[8]=1, saturating at c_clk_hz/1000*c_reset_hold_ms.
REQ-024 o_reset SHALL assert on the cycle the counter reaches that terminal value and stay 1 while btn_f[8] stays 1.
REQ-025 Release of btn_f[8] SHALL clear the counter and o_reset on the next cycle.
REQ-026 A release before the terminal value SHALL restart the count from 0.
REQ-027 With c_reset_hold_ms=0, o_reset SHALL equal btn_f[8] delayed one cycle.

Reset
REQ-028 i_rst_n=0 SHALL immediately clear the synchronizer, btn_f, sr, o_bitcnt, the hold counter and o_reset, so o_data=0.
REQ-029 Reset asserted mid-read-sequence SHALL discard the sequence; after reset the next bit appears only after a new strobe.

Structure
REQ-030 Package usbh_nes_pkg SHALL hold the button index constants (A=0 .. R=7, RST=8) and c_nes_bits=8.
REQ-031 The hold counter SHALL be sub-module usbh_nes_reset_hold (ports: clock, reset, level in, o_reset; parameter: cycle count).

Verification
REQ-032 Bench SHALL drive i_btn=9'h009 (A+Start), strobe 1->0, then 10 reads -> o_data sequence 1,0,0,1,0,0,0,0,1,1; o_bitcnt ends at 8.
REQ-033 Bench SHALL drive i_btn=9'h030 (U+D) -> reads 5 and 6 both 0; i_btn=9'h0F0 -> reads 5..8 all 1.
REQ-034 Bench SHALL drop the strobe with i_btn=9'h001, then change i_btn to 9'h002 -> first read returns 1, second returns 0.
REQ-035 Bench SHALL pulse i_strobe=1 and i_read=1 in the same cycle -> sr reloads, o_bitcnt=0, no shift.
REQ-036 With c_clk_hz=1000 and c_reset_hold_ms=10, bench SHALL hold i_btn[8] for 9 cycles then release, then hold 20 cycles -> first hold gives no o_reset; second asserts o_reset 3+10 cycles after the press; o_reset drops after release.
REQ-037 Bench SHALL assert i_rst_n=0 after 3 reads -> o_data=0 and o_bitcnt=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/usbh_nes_pkg.sv
// Shared constants for the NES joypad emulation behind the USB HID decoder.
package usbh_nes_pkg;

  // Bit positions in the decoder button vector {reset,R,L,D,U,start,select,B,A}
  localparam int c_btn_a      = 0;
  localparam int c_btn_b      = 1;
  localparam int c_btn_select = 2;
  localparam int c_btn_start  = 3;
  localparam int c_btn_up     = 4;
  localparam int c_btn_down   = 5;
  localparam int c_btn_left   = 6;
  localparam int c_btn_right  = 7;
  localparam int c_btn_rst    = 8;

  // Number of buttons shifted out to the CPU per strobe
  localparam int c_nes_bits   = 8;

endpackage

// File: rtl/usbh_nes_reset_hold.sv
// Long-press detector: o_reset rises once i_level has been high for c_cycles
// consecutive cycles and stays up until i_level drops.
module usbh_nes_reset_hold #(
  parameter int c_cycles = 3000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_reset
);

  localparam int            CW     = (c_cycles < 1) ? 1 : $clog2(c_cycles + 1);
  localparam logic [CW-1:0] c_term = CW'(c_cycles);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          reset_q, reset_d;

  // Saturating hold count; any release drops it back to zero.
  // With c_cycles=0 the terminal value is already reached, so o_reset is the
  // level delayed by one cycle.
  always_comb begin
    cnt_d   = '0;
    reset_d = 1'b0;
    if (i_level) begin
      cnt_d   = (cnt_q == c_term) ? c_term : cnt_q + CW'(1);
      reset_d = (cnt_d == c_term);
    end
  end

  // Counter and registered reset request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      reset_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      reset_q <= reset_d;
    end
  end

  assign o_reset = reset_q;

endmodule

// File: rtl/usbh_nes_joypad.sv
// NES controller port emulation: synchronizes decoder button state, filters
// impossible direction pairs, and serves it through the $4016 strobe/read
// shift protocol. Holding the reset button long enough requests a console reset.
module usbh_nes_joypad #(
  parameter int c_clk_hz         = 6000000,
  parameter int c_reset_hold_ms  = 500,
  parameter int c_block_opposite = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_btn,
  input  logic       i_strobe,
  input  logic       i_read,
  output logic       o_data,
  output logic [3:0] o_bitcnt,
  output logic       o_reset
);

  import usbh_nes_pkg::*;

  localparam int         c_hold_cycles = c_clk_hz / 1000 * c_reset_hold_ms;
  localparam logic [3:0] c_cnt_max     = 4'(c_nes_bits);

  logic [8:0]            sync1_q, sync2_q, btn_f_q, btn_filt;
  logic [c_nes_bits-1:0] sr_q;
  logic [3:0]            cnt_q;

  // Two-flop synchronizer, then the filtered button register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      btn_f_q <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      btn_f_q <= btn_filt;
    end
  end

  // Drop opposing direction pairs; a full four-way press is passed as-is
  // since it is more likely a deliberate combo than a rocking d-pad.
  always_comb begin
    btn_filt = sync2_q;
    if (c_block_opposite != 0 && !(&sync2_q[c_btn_right:c_btn_up])) begin
      if (sync2_q[c_btn_up] && sync2_q[c_btn_down]) begin
        btn_filt[c_btn_up]   = 1'b0;
        btn_filt[c_btn_down] = 1'b0;
      end
      if (sync2_q[c_btn_left] && sync2_q[c_btn_right]) begin
        btn_filt[c_btn_left]  = 1'b0;
        btn_filt[c_btn_right] = 1'b0;
      end
    end
  end

  // Strobe loads continuously (and wins over a read); reads shift in ones
  // so that reads past the eighth return 1 like original hardware.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (i_strobe) begin
      sr_q  <= btn_f_q[c_nes_bits-1:0];
      cnt_q <= '0;
    end else if (i_read) begin
      sr_q  <= {1'b1, sr_q[c_nes_bits-1:1]};
      cnt_q <= (cnt_q == c_cnt_max) ? c_cnt_max : cnt_q + 4'd1;
    end
  end

  assign o_data   = sr_q[0];
  assign o_bitcnt = cnt_q;

  usbh_nes_reset_hold #(
    .c_cycles (c_hold_cycles)
  ) u_reset_hold (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_level (btn_f_q[c_btn_rst]),
    .o_reset (o_reset)
  );

endmodule

// File: tb/tb_usbh_nes_joypad.sv
// Directed bench for usbh_nes_joypad with a 10-cycle reset hold time.
module tb_usbh_nes_joypad;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] btn;
  logic       strobe;
  logic       rd;
  logic       data;
  logic [3:0] bitcnt;
  logic       nes_reset;

  int checks = 0;
  int errors = 0;

  usbh_nes_joypad #(
    .c_clk_hz         (1000),
    .c_reset_hold_ms  (10),
    .c_block_opposite (1)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_btn    (btn),
    .i_strobe (strobe),
    .i_read   (rd),
    .o_data   (data),
    .o_bitcnt (bitcnt),
    .o_reset  (nes_reset)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Let buttons settle through sync+filter, then pulse the strobe
  task automatic latch(input logic [8:0] b);
    btn = b;
    tick(4);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic do_read();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  // Check each of 8 reads against the expected button byte, A first
  task automatic read8(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    e = exp;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_bit%0d", tag, i), {7'd0, data}, {7'd0, e[i]});
      do_read();
    end
  endtask

  initial begin
    logic [9:0] seq;
    rst_n  = 1'b0;
    btn    = '0;
    strobe = 1'b0;
    rd     = 1'b0;
    #2;
    check("rst_data",   {7'd0, data},      8'd0);
    check("rst_bitcnt", {4'd0, bitcnt},    8'd0);
    check("rst_oreset", {7'd0, nes_reset}, 8'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // A+Start: reads 1,0,0,1,0,0,0,0 then ones
    latch(9'h009);
    seq = 10'b11_0000_1001;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("as_bit%0d", i), {7'd0, data}, {7'd0, seq[i]});
      check($sformatf("as_cnt%0d", i), {4'd0, bitcnt}, (i > 8) ? 8'd8 : 8'(i));
      do_read();
    end
    check("as_cnt_end", {4'd0, bitcnt}, 8'd8);

    // Opposite directions cancel; all four pass through
    latch(9'h030);
    read8("ud", 8'h00);
    latch(9'h0C0);
    read8("lr", 8'h00);
    latch(9'h0F0);
    read8("all4", 8'hF0);
    latch(9'h050);
    read8("ul", 8'h50);

    // Strobe fall freezes the value
    latch(9'h001);
    btn = 9'h002;
    tick(5);
    check("frz_r1", {7'd0, data}, 8'd1);
    do_read();
    check("frz_r2", {7'd0, data}, 8'd0);
    do_read();
    check("frz_cnt", {4'd0, bitcnt}, 8'd2);

    // Strobe and read together: load wins
    btn = 9'h001;
    tick(4);
    strobe = 1'b1;
    rd     = 1'b1;
    tick();
    strobe = 1'b0;
    rd     = 1'b0;
    check("sr_data", {7'd0, data},   8'd1);
    check("sr_cnt",  {4'd0, bitcnt}, 8'd0);
    do_read();
    check("sr_next", {7'd0, data},   8'd0);
    check("sr_cnt1", {4'd0, bitcnt}, 8'd1);

    // Reset hold: 9-cycle press must not trigger
    btn = 9'h100;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("h1_%0d", k), {7'd0, nes_reset}, 8'd0);
    end
    btn = 9'h000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("h1r_%0d", k), {7'd0, nes_reset}, 8'd0);
    end
    // 20-cycle press asserts 3+10 cycles after the press
    btn = 9'h100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("h2_%0d", k), {7'd0, nes_reset}, (k >= 13) ? 8'd1 : 8'd0);
    end
    btn = 9'h000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("h2r_%0d", k), {7'd0, nes_reset}, (k <= 3) ? 8'd1 : 8'd0);
    end

    // Reset in the middle of a read sequence
    latch(9'h0FF);
    do_read();
    do_read();
    do_read();
    check("mid_pre_data", {7'd0, data},   8'd1);
    check("mid_pre_cnt",  {4'd0, bitcnt}, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", {7'd0, data},   8'd0);
    check("mid_rst_cnt",  {4'd0, bitcnt}, 8'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("post_rst_data", {7'd0, data},   8'd0);
    check("post_rst_cnt",  {4'd0, bitcnt}, 8'd0);
    latch(9'h0FF);
    check("post_strobe", {7'd0, data}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
